uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
Oversampling UART receiver that sits directly upstream of the line-buffer FIFO. It converts the asynchronous serial line into byte strobes for the FIFO write port. Compared with the plain receiver it adds three things: majority-vote bit sampling, false-start rejection, and framing-error and break detection. Frame format is fixed at 8N1, LSB first.

Parameters:
CLOCKS_PER_BAUD, 217, clock cycles per bit (25 MHz / 115200); legal range 16..65535.
CW, 16, width of the baud counter; must hold CLOCKS_PER_BAUD-1.

Ports:
i_clk  input  1  system clock; one clock domain.
i_reset  input  1  synchronous, active-high reset.
i_uart_rx  input  1  asynchronous serial line; idle high.
o_wr  output  1  one-cycle strobe; o_data holds a valid byte.
o_data  output  8  received byte; held until the next o_wr.
o_frame_err  output  1  one-cycle strobe; stop bit sampled low.
o_break  output  1  one-cycle strobe; break detected (all-zero data plus low stop bit).
o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Synchronizer: 2-flop synchronizer on i_uart_rx, both flops reset to 1. All logic uses the synchronized value rx_s. The synchronizer adds 2 cycles of latency.
- Sampling:
  - Baud counter bcnt counts 0..CLOCKS_PER_BAUD-1 within each bit; MID = CLOCKS_PER_BAUD/2.
  - Samples are taken at bcnt = MID-1, MID and MID+1.
  - The bit value is the majority of the three samples and is decided at bcnt = MID+1.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s==0 (falling edge seen as low while idle), clear bcnt and go to START.
  - START: when the majority decides 1, the start was false; return to IDLE with no strobe. When it decides 0, continue. At bcnt = CLOCKS_PER_BAUD-1, wrap bcnt to 0 and go to DATA with bit index 0.
  - DATA: on each majority decision, shift the bit into a shift register from the MSB side, so the result is LSB first. At the end of bit 7's period, go to STOP.
  - STOP: the majority decision acts immediately; there is no wait for the end of the stop bit, which allows back-to-back frames.
    - Decided 1: the next cycle gives o_wr=1 and o_data=shift register; go to IDLE.
    - Decided 0: the next cycle gives o_frame_err=1. o_break is also 1 if the shift register is 0x00. o_wr stays 0 and o_data is unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s has been 1 for CLOCKS_PER_BAUD consecutive cycles, then go to IDLE. A low sample restarts the count. No strobes are generated while in this state, so a long break produces exactly one o_frame_err/o_break.
- Latency: o_wr rises 2 + 9*CLOCKS_PER_BAUD + MID + 2 cycles after the line's falling edge at the pin (±1 for synchronizer phase).
- Strobes: o_wr, o_frame_err and o_break are each exactly one cycle wide. o_wr and o_frame_err are never asserted together.
- Reset values: o_wr=0, o_frame_err=0, o_break=0, o_busy=0, o_data=0x00, state=IDLE, bcnt=0, shift register=0.
- Reset mid-frame: the state returns to IDLE on the next edge and the partial byte is discarded. If the line is low after reset releases, that is treated as a new start. That start is rejected only if its majority sample reads high.
- Width and arithmetic:
  - bcnt wraps exactly at CLOCKS_PER_BAUD-1, with no off-by-one drift.
  - The bit index is 3 bits; DATA exits after index 7.
  - The WAIT_IDLE counter reuses bcnt.
- There is no backpressure. The downstream FIFO must accept o_wr unconditionally. Overflow is the FIFO's concern.

Test Plan:
- Nominal byte: send 0x55 at 217 cycles/bit, then line high → exactly one o_wr with o_data=0x55, at 2+9*217+108+2 cycles (±1) after the start edge; o_frame_err=0; o_busy low afterwards.
- Back-to-back bytes: 0x0A then 0x0D with one stop bit and no idle gap → two o_wr strobes with 0x0A then 0x0D, spaced 10*217 cycles apart (±1).
- Glitches:
  - 40-cycle low pulse on an idle line → no strobes; o_busy returns low within CLOCKS_PER_BAUD cycles.
  - Single-cycle inverted glitch at bcnt=MID in bit 3 of 0xA5 → majority filters it; o_data=0xA5.
- Framing error: 0xA5 with stop bit held low, then line high → one o_frame_err, o_break=0, no o_wr, o_data keeps its previous value; the next valid 0x3C is received correctly.
- Break: line low for 20 bit times, then high → exactly one o_frame_err plus o_break in the same cycle, no o_wr; a subsequent 0x41 is received only after the line has been high for 217 cycles.
- Reset mid-frame: assert i_reset for 1 cycle during bit 4 of 0xFF, with the line held high after reset → all outputs 0, no o_wr for that frame; the next 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Receive-side strobe bundle from uart_rx_sampler towards the line-buffer FIFO write port.
// The master drives the strobes and byte; the slave (FIFO side) only observes them.
interface uart_rx_sampler_if;
    logic       o_wr;
    logic [7:0] o_data;
    logic       o_frame_err;
    logic       o_break;
    logic       o_busy;

    modport master (
        output o_wr,
        output o_data,
        output o_frame_err,
        output o_break,
        output o_busy
    );

    modport slave (
        input o_wr,
        input o_data,
        input o_frame_err,
        input o_break,
        input o_busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 oversampling UART receiver: majority-vote sampling, false-start reject, framing/break detect.
// o_wr lands about 2 + 9.5 bit times after the start edge; no backpressure, every strobe must be taken.
module uart_rx_sampler #(
    parameter int CLOCKS_PER_BAUD = 217,
    parameter int CW              = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_uart_rx,
    uart_rx_sampler_if.master  rx_out
);

    localparam logic [CW-1:0] LAST   = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] MID    = CW'(CLOCKS_PER_BAUD / 2);
    localparam logic [CW-1:0] MID_M1 = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] MID_P1 = CW'(CLOCKS_PER_BAUD / 2 + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] bcnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          smp_a;
    logic          smp_b;
    logic          maj;
    logic          at_last;
    logic          at_dec;
    logic          wr_d;
    logic          ferr_d;
    logic          brk_d;
    logic          wr_q;
    logic          ferr_q;
    logic          brk_q;
    logic [7:0]    data_q;

    assign at_last = (bcnt == LAST);
    assign at_dec  = (bcnt == MID_P1);
    // Third vote is the live sample taken on the deciding cycle itself.
    assign maj     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (at_dec && maj)  state_d = IDLE;
                else if (at_last)   state_d = DATA;
            end
            DATA: begin
                if (at_last && (bit_idx == 3'd7)) state_d = STOP;
            end
            STOP: begin
                if (at_dec) state_d = maj ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s && at_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d   = 1'b0;
        ferr_d = 1'b0;
        brk_d  = 1'b0;
        if (state_q == STOP && at_dec) begin
            wr_d   = maj;
            ferr_d = !maj;
            brk_d  = !maj && (shift == 8'h00);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            bcnt    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            rx_m <= i_uart_rx;
            rx_s <= rx_m;

            unique case (state_q)
                IDLE:      bcnt <= '0;
                // Counts consecutive high cycles; any low sample starts over.
                WAIT_IDLE: bcnt <= (!rx_s || at_last) ? '0 : bcnt + CW'(1);
                default:   bcnt <= ((state_d != state_q) || at_last) ? '0 : bcnt + CW'(1);
            endcase

            if (state_q == START) begin
                bit_idx <= 3'd0;
            end else if (state_q == DATA && at_last) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (bcnt == MID_M1) smp_a <= rx_s;
            if (bcnt == MID)    smp_b <= rx_s;

            if (state_q == DATA && at_dec) begin
                shift <= {maj, shift[7:1]};
            end

            wr_q   <= wr_d;
            ferr_q <= ferr_d;
            brk_q  <= brk_d;
            if (wr_d) data_q <= shift;
        end
    end

    assign rx_out.o_wr        = wr_q;
    assign rx_out.o_data      = data_q;
    assign rx_out.o_frame_err = ferr_q;
    assign rx_out.o_break     = brk_q;
    assign rx_out.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: nominal, back-to-back, glitches, framing error, break, reset mid-frame.
module tb_uart_rx_sampler;

    localparam int CPB = 217;
    localparam int LAT = 2 + 9 * CPB + CPB / 2 + 2;

    logic i_clk;
    logic i_reset;
    logic i_uart_rx;

    uart_rx_sampler_if bus ();

    uart_rx_sampler #(
        .CLOCKS_PER_BAUD (CPB),
        .CW              (16)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_uart_rx (i_uart_rx),
        .rx_out    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         wr_cnt = 0;
    int         ferr_cnt = 0;
    int         brk_cnt = 0;
    int         brk_ferr_cnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    int         last_wr_cyc = 0;
    int         prev_wr_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       wr_prev = 1'b0;
    logic       ferr_prev = 1'b0;
    logic       brk_prev = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (bus.o_wr) begin
            wr_cnt++;
            prev_data   = last_data;
            last_data   = bus.o_data;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
        end
        if (bus.o_frame_err) ferr_cnt++;
        if (bus.o_break) brk_cnt++;
        if (bus.o_break && bus.o_frame_err) brk_ferr_cnt++;
        if (bus.o_wr && bus.o_frame_err) overlap_cnt++;
        if ((bus.o_wr && wr_prev) || (bus.o_frame_err && ferr_prev) || (bus.o_break && brk_prev))
            wide_cnt++;
        wr_prev   = bus.o_wr;
        ferr_prev = bus.o_frame_err;
        brk_prev  = bus.o_break;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_uart_rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drives a full 10-bit frame; cycle goff (if >= 0) is inverted as a glitch.
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int goff);
        logic [9:0] fr;
        logic       b;
        fr = {stopv, d, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            b = fr[i / CPB];
            if (i == goff) b = ~b;
            i_uart_rx = b;
            tick();
        end
    endtask

    int w0, f0, b0, bf0, s0, lat, gap;
    logic [9:0] ffr;

    initial begin
        i_reset   = 1'b1;
        i_uart_rx = 1'b1;
        repeat (3) tick();
        chk("rst_wr",   32'(bus.o_wr), 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_ferr", 32'(bus.o_frame_err), 0);
        chk("rst_brk",  32'(bus.o_break), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        i_reset = 1'b0;
        idle(20);

        // Nominal byte and start-edge-to-strobe latency
        w0 = wr_cnt; f0 = ferr_cnt; s0 = cyc;
        send_frame(8'h55, 1'b1, -1);
        idle(300);
        chk("nom_cnt",  32'(wr_cnt - w0), 1);
        chk("nom_data", 32'(last_data), 32'h55);
        lat = last_wr_cyc - s0;
        chk("nom_lat",  32'((lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat), 32'(LAT));
        chk("nom_ferr", 32'(ferr_cnt - f0), 0);
        chk("nom_busy", 32'(bus.o_busy), 0);

        // Back-to-back frames with no idle gap
        w0 = wr_cnt;
        send_frame(8'h0A, 1'b1, -1);
        send_frame(8'h0D, 1'b1, -1);
        idle(300);
        chk("b2b_cnt",    32'(wr_cnt - w0), 2);
        chk("b2b_first",  32'(prev_data), 32'h0A);
        chk("b2b_second", 32'(last_data), 32'h0D);
        gap = last_wr_cyc - prev_wr_cyc;
        chk("b2b_gap", 32'((gap >= 10 * CPB - 1 && gap <= 10 * CPB + 1) ? 10 * CPB : gap), 32'(10 * CPB));

        // 40-cycle false start
        w0 = wr_cnt; f0 = ferr_cnt;
        i_uart_rx = 1'b0;
        repeat (40) tick();
        chk("pulse_busy_hi", 32'(bus.o_busy), 1);
        idle(CPB - 40);
        chk("pulse_busy_lo", 32'(bus.o_busy), 0);
        idle(100);
        chk("pulse_wr",   32'(wr_cnt - w0), 0);
        chk("pulse_ferr", 32'(ferr_cnt - f0), 0);

        // Framing error keeps the previous byte, then a clean frame
        w0 = wr_cnt; f0 = ferr_cnt; b0 = brk_cnt;
        send_frame(8'hA5, 1'b0, -1);
        idle(300);
        chk("fe_ferr", 32'(ferr_cnt - f0), 1);
        chk("fe_brk",  32'(brk_cnt - b0), 0);
        chk("fe_wr",   32'(wr_cnt - w0), 0);
        chk("fe_data", 32'(bus.o_data), 32'h0D);
        send_frame(8'h3C, 1'b1, -1);
        idle(300);
        chk("fe_next_cnt",  32'(wr_cnt - w0), 1);
        chk("fe_next_data", 32'(last_data), 32'h3C);

        // One-cycle glitch in the middle of bit 3
        w0 = wr_cnt;
        send_frame(8'hA5, 1'b1, 4 * CPB + CPB / 2 + 1);
        idle(300);
        chk("gl_cnt",  32'(wr_cnt - w0), 1);
        chk("gl_data", 32'(last_data), 32'hA5);

        // Break: 20 bit times low
        w0 = wr_cnt; f0 = ferr_cnt; b0 = brk_cnt; bf0 = brk_ferr_cnt;
        i_uart_rx = 1'b0;
        repeat (20 * CPB) tick();
        idle(100);
        chk("brk_busy_wait", 32'(bus.o_busy), 1);
        chk("brk_ferr", 32'(ferr_cnt - f0), 1);
        chk("brk_brk",  32'(brk_cnt - b0), 1);
        chk("brk_same", 32'(brk_ferr_cnt - bf0), 1);
        chk("brk_wr",   32'(wr_cnt - w0), 0);
        idle(200);
        chk("brk_busy_lo", 32'(bus.o_busy), 0);
        send_frame(8'h41, 1'b1, -1);
        idle(300);
        chk("brk_next_cnt",  32'(wr_cnt - w0), 1);
        chk("brk_next_data", 32'(last_data), 32'h41);

        // Reset during bit 4 of 0xFF
        w0 = wr_cnt;
        ffr = {1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < 5 * CPB + 100; i++) begin
            i_uart_rx = ffr[i / CPB];
            tick();
        end
        i_uart_rx = 1'b1;
        i_reset   = 1'b1;
        tick();
        i_reset   = 1'b0;
        chk("mr_wr",   32'(bus.o_wr), 0);
        chk("mr_data", 32'(bus.o_data), 0);
        chk("mr_ferr", 32'(bus.o_frame_err), 0);
        chk("mr_brk",  32'(bus.o_break), 0);
        chk("mr_busy", 32'(bus.o_busy), 0);
        idle(2500);
        chk("mr_no_wr", 32'(wr_cnt - w0), 0);
        send_frame(8'h12, 1'b1, -1);
        idle(300);
        chk("mr_next_cnt",  32'(wr_cnt - w0), 1);
        chk("mr_next_data", 32'(last_data), 32'h12);

        chk("strobe_overlap", 32'(overlap_cnt), 0);
        chk("strobe_width",   32'(wide_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
